// File: rtl/piso_serializer.sv
// Parallel-in serial-out serializer: captures a WIDTH-bit word and shifts it out MSB first.
// Define PISO_PARITY_EN to append an even-parity bit after the last data bit.
module piso_serializer #(
  parameter int WIDTH = 6
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] din,
  input  logic             load_valid,
  output logic             load_ready,
  output logic             so,
  output logic             so_valid,
  output logic             done
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

`ifdef PISO_PARITY_EN
  typedef enum logic [1:0] {IDLE, SHIFT, PARITY} state_t;
`else
  typedef enum logic {IDLE, SHIFT} state_t;
`endif

  state_t           state_q, state_n;
  logic [WIDTH-1:0] sreg_q, sreg_n;
  logic [CW-1:0]    cnt_q, cnt_n;
`ifdef PISO_PARITY_EN
  logic             par_q, par_n;
`endif

  // Handshake: a word is taken on any edge where load_valid && load_ready.
  // load_ready is high in IDLE and during the final bit, so frames can abut.
  always_comb begin
    state_n    = state_q;
    sreg_n     = sreg_q;
    cnt_n      = cnt_q;
`ifdef PISO_PARITY_EN
    par_n      = par_q;
`endif
    so         = 1'b0;
    so_valid   = 1'b0;
    done       = 1'b0;
    load_ready = 1'b0;

    case (state_q)
      IDLE: begin
        load_ready = 1'b1;
      end
      SHIFT: begin
        so       = sreg_q[WIDTH-1];
        so_valid = 1'b1;
        sreg_n   = {sreg_q[WIDTH-2:0], 1'b0};
        cnt_n    = cnt_q + 1'b1;
        if (cnt_q == LAST) begin
`ifdef PISO_PARITY_EN
          state_n = PARITY;
          cnt_n   = '0;
`else
          done       = 1'b1;
          load_ready = 1'b1;
          state_n    = IDLE;
          cnt_n      = '0;
          sreg_n     = '0;
`endif
        end
      end
`ifdef PISO_PARITY_EN
      PARITY: begin
        so         = par_q;
        so_valid   = 1'b1;
        done       = 1'b1;
        load_ready = 1'b1;
        state_n    = IDLE;
        cnt_n      = '0;
        sreg_n     = '0;
      end
`endif
      default: begin
        state_n = IDLE;
      end
    endcase

    // A new word overrides the return to IDLE, giving gapless back-to-back frames.
    if (load_valid && load_ready) begin
      state_n = SHIFT;
      sreg_n  = din;
      cnt_n   = '0;
`ifdef PISO_PARITY_EN
      par_n   = ^din;
`endif
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      sreg_q  <= '0;
      cnt_q   <= '0;
`ifdef PISO_PARITY_EN
      par_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_n;
      sreg_q  <= sreg_n;
      cnt_q   <= cnt_n;
`ifdef PISO_PARITY_EN
      par_q   <= par_n;
`endif
    end
  end

endmodule

// File: doc/piso_serializer.md
PISO_SERIALIZER -- requirements
Module: piso_serializer

Interface
REQ-001 Parameter WIDTH, default 6, is the parallel word width; legal range is 2 to 32.
REQ-002 Port clk, input, 1 bit, is the single clock; all state updates on its rising edge.
REQ-003 Port reset, input, 1 bit, is a synchronous, active-high reset sampled on the rising edge of clk.
REQ-004 Port din, input, WIDTH bits, is the parallel word to transmit.
REQ-005 Port load_valid, input, 1 bit, means din holds a word offered for transmission.
REQ-006 Port load_ready, output, 1 bit, means the block accepts din on this edge if load_valid is high.
REQ-007 Port so, output, 1 bit, is the serial data bit for the current cycle.
REQ-008 Port so_valid, output, 1 bit, means so carries a frame bit this cycle.
REQ-009 Port done, output, 1 bit, is high during the last bit of each frame.

Function
REQ-010 The block SHALL have states IDLE and SHIFT, plus PARITY when PISO_PARITY_EN is defined.
REQ-011 A load is accepted on an edge where load_valid and load_ready are both high and reset is low.
REQ-012 load_ready SHALL be high in IDLE and in the final-bit cycle of a frame, and low otherwise.
REQ-013 On an accepted load from IDLE, the next cycle SHALL present so=din[WIDTH-1] with so_valid=1, and state SHALL be SHIFT.
REQ-014 The frame SHALL be sent MSB first, one bit per cycle; bit k (k=0..WIDTH-1) appears k cycles after the first bit.
REQ-015 din SHALL be captured at acceptance; later changes to din SHALL NOT affect the frame in flight.
REQ-016 A bit counter of ceil(log2(WIDTH)) bits SHALL track position; wrap-around beyond WIDTH-1 is forbidden.
REQ-017 Without parity, done=1 while bit din[0] is presented; with parity, done=1 while the parity bit is presented.
REQ-018 A load accepted in the final-bit cycle SHALL start the next frame in the immediately following cycle, with no gap.
REQ-019 With no load accepted in the final-bit cycle, the next cycle SHALL be IDLE with so=0 and so_valid=0.
REQ-020 load_valid asserted while load_ready=0 SHALL be ignored and SHALL NOT corrupt the frame in flight.
REQ-021 In IDLE, so=0, so_valid=0 and done=0.
REQ-022 Total latency is fixed: WIDTH cycles per frame without parity, or WIDTH+1 cycles with parity.

Reset
REQ-023 While reset is high at a clock edge, the state SHALL become IDLE, the counter and shift register SHALL be 0, and so, so_valid and done SHALL be 0 from the next cycle.
REQ-024 A load_valid high in the same edge as reset SHALL be discarded.
REQ-025 Reset mid-frame SHALL abort the frame immediately; no remaining bits are sent, and load_ready=1 in the following cycle.

Configuration
REQ-026 Macro PISO_PARITY_EN, when defined, SHALL append one even-parity bit (XOR of the captured word) after din[0], in state PARITY, with so_valid=1.
REQ-027 Without PISO_PARITY_EN, the PARITY state and parity logic SHALL NOT exist, and frames are exactly WIDTH bits.

Verification
REQ-028 WIDTH=6, no macro, load din=6'b101101 -> so=1,0,1,1,0,1 on cycles 1-6, so_valid=1 throughout, done=1 on cycle 6 only, IDLE on cycle 7.
REQ-029 WIDTH=6, PISO_PARITY_EN defined, load din=6'b101101 -> data bits as in REQ-028, then cycle 7 so=0 (parity), done=1 on cycle 7 only; for din=6'b101100 the parity bit is 1.
REQ-030 Back-to-back loads of 6'b111000 then 6'b000111 (second offered in the final-bit cycle) -> 12 contiguous valid bits 111000000111, done high on cycles 6 and 12.
REQ-031 Reset asserted after 3 bits of 6'b110011 -> next cycle so=0, so_valid=0, done=0, load_ready=1; a new load of 6'b010101 then sends correctly.
REQ-032 During a frame of 6'b100001, hold load_valid=1 with din=6'b011110 on cycles 2-4 -> those loads are ignored and the output is exactly 100001.
REQ-033 WIDTH=4 instance, load din=4'b1001 -> so=1,0,0,1 on cycles 1-4, done=1 on cycle 4.
